// File: rtl/im_addr_sequencer.sv
// Read-address sequencer for the instruction memory: a prescaler tick steps the
// address when every enable is high, with loop/one-shot modes, pause and restart.
module im_addr_sequencer #(
  parameter int CLK_DIV = 500000,
  parameter int ADDR_W  = 4,
  parameter int N_ENA   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ENA-1:0]  ena,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] Rdadress,
  output logic              tick,
  output logic              wrap,
  output logic              busy,
  output logic              done
);

  localparam int PRE_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t            r_state;
  logic [PRE_W-1:0]  r_pre;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_last;
  logic              r_mode;
  logic              r_tick;
  logic              r_wrap;
  logic              r_done;

  logic              w_enAll;
  logic              w_preEnd;

  assign w_enAll  = &ena;
  assign w_preEnd = (r_pre == PRE_W'(CLK_DIV - 1));

  // A PAUSE with the enables restored counts in the same cycle it returns to RUN,
  // so the prescaler resumes exactly where it froze.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pre   <= '0;
      r_addr  <= '0;
      r_last  <= '0;
      r_mode  <= 1'b0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      if (start) begin
        r_state <= RUN;
        r_pre   <= '0;
        r_addr  <= '0;
        r_last  <= last_addr;
        r_mode  <= mode;
      end else if (r_state != IDLE) begin
        if (!w_enAll) begin
          r_state <= PAUSE;
        end else begin
          r_state <= RUN;
          if (!w_preEnd) begin
            r_pre <= r_pre + 1'b1;
          end else begin
            r_pre  <= '0;
            r_tick <= 1'b1;
            if (r_addr != r_last) begin
              r_addr <= r_addr + 1'b1;
            end else if (!r_mode) begin
              r_addr <= '0;
              r_wrap <= 1'b1;
            end else begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
      end
    end
  end

  assign Rdadress = r_addr;
  assign tick     = r_tick;
  assign wrap     = r_wrap;
  assign done     = r_done;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_im_addr_sequencer.sv
// Directed bench for im_addr_sequencer (CLK_DIV=4): a cycle model queues the
// expected outputs for every driven cycle and they are compared after the edge.
module tb_im_addr_sequencer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ena;
  logic       start;
  logic       mode;
  logic [3:0] last_addr;
  logic [3:0] Rdadress;
  logic       tick, wrap, busy, done;

  typedef struct packed {
    logic [3:0] addr;
    logic       tick;
    logic       wrap;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t expQ[$];
  exp_t obs;
  int   vectors = 0;
  int   fails   = 0;

  // Reference state: 0 idle, 1 run, 2 pause
  int         mState = 0;
  int         mPre   = 0;
  logic [3:0] mAddr  = '0;
  logic [3:0] mLast  = '0;
  logic       mMode  = 1'b0;

  im_addr_sequencer #(.CLK_DIV(DIV), .ADDR_W(4), .N_ENA(2)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .mode(mode),
    .last_addr(last_addr), .Rdadress(Rdadress), .tick(tick), .wrap(wrap),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input string tag);
    exp_t e;
    e = '0;
    if (rst) begin
      mState = 0; mPre = 0; mAddr = '0; mLast = '0; mMode = 1'b0;
    end else if (start) begin
      mState = 1; mPre = 0; mAddr = '0; mLast = last_addr; mMode = mode;
    end else if (mState != 0) begin
      if (ena != 2'b11) begin
        mState = 2;
      end else begin
        mState = 1;
        if (mPre < DIV - 1) begin
          mPre++;
        end else begin
          mPre = 0;
          e.tick = 1'b1;
          if (mAddr != mLast) mAddr = mAddr + 4'd1;
          else if (mMode == 1'b0) begin mAddr = '0; e.wrap = 1'b1; end
          else begin e.done = 1'b1; mState = 0; end
        end
      end
    end
    e.addr = mAddr;
    e.busy = (mState != 0);
    expQ.push_back(e);
    @(posedge clk);
    #1;
    obs = '{addr: Rdadress, tick: tick, wrap: wrap, busy: busy, done: done};
    e = expQ.pop_front();
    vectors++;
    assert (obs === e) else begin
      fails++;
      $error("[TB] FAIL %s: observed addr=%0d tick=%b wrap=%b busy=%b done=%b, expected addr=%0d tick=%b wrap=%b busy=%b done=%b",
             tag, obs.addr, obs.tick, obs.wrap, obs.busy, obs.done,
             e.addr, e.tick, e.wrap, e.busy, e.done);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t want);
    vectors++;
    assert (obs === want) else begin
      fails++;
      $error("[TB] FAIL %s: observed %b, expected %b (addr,tick,wrap,busy,done)", tag, obs, want);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ena = 2'b11; mode = 1'b0; last_addr = 4'd0;

    // Reset held, then a start that reset must override
    repeat (3) applyStimulus("reset_hold");
    start = 1'b1; last_addr = 4'd3;
    applyStimulus("reset_vs_start");
    checkOutput("reset_state", '{addr: 4'd0, tick: 1'b0, wrap: 1'b0, busy: 1'b0, done: 1'b0});
    rst = 1'b0; start = 1'b0;
    applyStimulus("idle_after_reset");

    // Loop 0..3; mode/last changes after start are ignored
    mode = 1'b0; last_addr = 4'd3; start = 1'b1;
    applyStimulus("loop_start");
    start = 1'b0; mode = 1'b1; last_addr = 4'd7;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus("loop_run");
      if (i == 3)  checkOutput("loop_pre_first_tick", '{addr: 4'd0, tick: 1'b0, wrap: 1'b0, busy: 1'b1, done: 1'b0});
      if (i == 4)  checkOutput("loop_first_tick",     '{addr: 4'd1, tick: 1'b1, wrap: 1'b0, busy: 1'b1, done: 1'b0});
      if (i == 16) checkOutput("loop_wrap",           '{addr: 4'd0, tick: 1'b1, wrap: 1'b1, busy: 1'b1, done: 1'b0});
    end

    // One-shot to address 2
    mode = 1'b1; last_addr = 4'd2; start = 1'b1;
    applyStimulus("oneshot_start");
    start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      applyStimulus("oneshot_run");
      if (i == 12) checkOutput("oneshot_done", '{addr: 4'd2, tick: 1'b1, wrap: 1'b0, busy: 1'b0, done: 1'b1});
      if (i == 15) checkOutput("oneshot_hold", '{addr: 4'd2, tick: 1'b0, wrap: 1'b0, busy: 1'b0, done: 1'b0});
    end

    // Loop to 15, pause at address 5 with prescaler 2
    mode = 1'b0; last_addr = 4'd15; start = 1'b1;
    applyStimulus("pause_start");
    start = 1'b0;
    repeat (22) applyStimulus("pause_advance");
    ena = 2'b01;
    repeat (10) applyStimulus("pause_frozen");
    checkOutput("pause_state", '{addr: 4'd5, tick: 1'b0, wrap: 1'b0, busy: 1'b1, done: 1'b0});
    ena = 2'b11;
    applyStimulus("resume_1");
    checkOutput("resume_no_tick", '{addr: 4'd5, tick: 1'b0, wrap: 1'b0, busy: 1'b1, done: 1'b0});
    applyStimulus("resume_2");
    checkOutput("resume_tick", '{addr: 4'd6, tick: 1'b1, wrap: 1'b0, busy: 1'b1, done: 1'b0});

    // Restart at address 7 on the cycle a tick is due
    repeat (7) applyStimulus("restart_advance");
    start = 1'b1;
    applyStimulus("restart");
    checkOutput("restart_state", '{addr: 4'd0, tick: 1'b0, wrap: 1'b0, busy: 1'b1, done: 1'b0});
    start = 1'b0;
    repeat (4) applyStimulus("restart_run");
    checkOutput("restart_next_tick", '{addr: 4'd1, tick: 1'b1, wrap: 1'b0, busy: 1'b1, done: 1'b0});

    // last=0 loop: wrap on every tick
    mode = 1'b0; last_addr = 4'd0; start = 1'b1;
    applyStimulus("last0_loop_start");
    start = 1'b0;
    for (int i = 1; i <= 12; i++) applyStimulus("last0_loop_run");
    checkOutput("last0_loop_wrap", '{addr: 4'd0, tick: 1'b1, wrap: 1'b1, busy: 1'b1, done: 1'b0});

    // last=0 one-shot: done at the first tick
    mode = 1'b1; start = 1'b1;
    applyStimulus("last0_oneshot_start");
    start = 1'b0;
    repeat (4) applyStimulus("last0_oneshot_run");
    checkOutput("last0_oneshot_done", '{addr: 4'd0, tick: 1'b1, wrap: 1'b0, busy: 1'b0, done: 1'b1});

    // Full-range loop through 15 back to 0
    mode = 1'b0; last_addr = 4'd15; start = 1'b1;
    applyStimulus("full_start");
    start = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      applyStimulus("full_run");
      if (i == 60) checkOutput("full_top", '{addr: 4'd15, tick: 1'b1, wrap: 1'b0, busy: 1'b1, done: 1'b0});
    end
    checkOutput("full_wrap", '{addr: 4'd0, tick: 1'b1, wrap: 1'b1, busy: 1'b1, done: 1'b0});

    // Reset in the middle of a run
    repeat (6) applyStimulus("midrun");
    rst = 1'b1;
    applyStimulus("midrun_reset");
    checkOutput("midrun_reset_state", '{addr: 4'd0, tick: 1'b0, wrap: 1'b0, busy: 1'b0, done: 1'b0});
    rst = 1'b0;
    repeat (5) applyStimulus("post_reset_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/im_addr_sequencer.md
Name: im_addr_sequencer

Overview:
Parametrised read-address sequencer that sits in front of the instruction memory. An internal prescaler produces a periodic tick, and each tick advances the read address. Advancing is gated by the AND of N_ENA enable inputs, which come from the general controller and the input controller. It adds programmable end address, loop/one-shot modes, pause-without-loss, restart, and status outputs.

Parameters:
CLK_DIV, 500000, clock cycles per address step (5 ms at 100 MHz); legal range ≥ 2.
ADDR_W, 4, width of the read address.
N_ENA, 2, number of enable inputs that are ANDed together.

Ports:
clk  input  1  system clock; everything is rising-edge.
rst  input  1  synchronous, active-high reset.
ena  input  N_ENA  enable vector; the sequencer advances only when all bits are 1.
start  input  1  one-cycle pulse that starts or restarts a sequence.
mode  input  1  0 = loop, 1 = one-shot; sampled on start.
last_addr  input  ADDR_W  final address of the sequence; sampled on start.
Rdadress  output  ADDR_W  current read address to the IM (registered).
tick  output  1  one-cycle pulse each time the prescaler expires.
wrap  output  1  one-cycle pulse when loop mode returns to 0.
busy  output  1  high in RUN or PAUSE.
done  output  1  one-cycle pulse when a one-shot sequence completes.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, Rdadress=0, prescaler=0, tick=wrap=done=busy=0, latched mode=0, latched last=0. Reset overrides start.
- Internal signal en_all = &ena (combinational).
- States: IDLE, RUN, PAUSE.
- IDLE: outputs hold. Rdadress keeps its last value. On start: Rdadress←0, prescaler←0, latch mode and last_addr, go to RUN.
- RUN with en_all=1:
  - The prescaler increments each cycle.
  - When prescaler==CLK_DIV-1: prescaler←0 and tick=1 on the next cycle, aligned with the Rdadress update.
  - First tick arrives CLK_DIV cycles after entering RUN.
- RUN with en_all=0: go to PAUSE. The prescaler and Rdadress freeze and are not cleared.
- PAUSE: when en_all returns to 1, go back to RUN and resume counting from the frozen prescaler value.
- Address step on each tick:
  - If Rdadress≠last: Rdadress←Rdadress+1.
  - If Rdadress==last in loop mode: Rdadress←0 and wrap=1.
  - If Rdadress==last in one-shot mode: Rdadress holds at last, done=1, go to IDLE.
- Boundaries:
  - last=0 in loop mode: Rdadress stays 0 and wrap pulses every tick.
  - last=0 in one-shot mode: done pulses at the first tick.
  - last=2^ADDR_W−1: natural wrap, no overflow beyond ADDR_W bits.
- start while in RUN or PAUSE: restarts immediately. Rdadress←0, prescaler←0, inputs re-latched, state→RUN. A tick due in the same cycle is discarded and no done/wrap is issued.
- start coinciding with a one-shot completion: start wins, no done pulse.
- Changes to mode or last_addr after start have no effect until the next start.
- busy=1 exactly while state is RUN or PAUSE. tick, wrap and done are never high for more than one cycle.

Test Plan:
1. Reset check (CLK_DIV=4, ADDR_W=4, N_ENA=2): hold rst 3 cycles, then drive start with rst still high → all outputs 0, state stays IDLE.
2. Loop mode (ena=2'b11, mode=0, last=3, start) → Rdadress goes 0,1,2,3,0,… changing every 4 cycles. First change occurs 4 cycles after start. wrap pulses on each 3→0 transition. busy=1 throughout.
3. One-shot (mode=1, last=2) → Rdadress 0,1,2. done pulses one cycle when the tick arrives at address 2. State returns to IDLE, busy=0, Rdadress holds at 2.
4. Pause (loop mode, last=15): drop ena[1] for 10 cycles when prescaler=2 and Rdadress=5 → Rdadress stays 5 and no tick occurs. After re-enabling, the next tick comes 2 cycles later and Rdadress becomes 6.
5. Restart: pulse start while Rdadress=7 in RUN, on the cycle a tick is due → Rdadress=0, no wrap/done, next tick 4 cycles later.
6. Edge cases:
   - last=0 in loop mode → Rdadress stays 0 and wrap pulses every 4 cycles.
   - last=15 in loop mode → address reaches 15, then 0, with wrap=1.
   - rst asserted mid-RUN → outputs return to reset values on the next edge.
